stage0_fetch: RTL and testbench
===============================

# stage0_fetch

Instruction fetch and decode stage of the emulated processor, directly upstream of STAGE1. It owns the program counter and fetches 32-bit instruction words from program memory over a req/ack handshake. It splits each word into the fields STAGE1 consumes (`mblock_s1`, `vr_source`) plus opcode and immediate for later stages, and presents them behind a valid/ready handshake. It also handles jump redirects and a HALT opcode.

## Interface
Parameters:
- `PC_WIDTH`, 16: program counter / `rom_address` width; matches STAGE1 `ram_address`.
- `RESET_PC`, 0: PC value after reset.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rom_address`  out  PC_WIDTH  fetch address (current PC).
- `rom_req`  out  1  fetch request.
- `rom_value`  in  32  instruction word; valid when `rom_ack`=1.
- `rom_ack`  in  1  fetch completion.
- `jump_valid`  in  1  redirect request from a downstream stage.
- `jump_target`  in  PC_WIDTH  redirect PC.
- `s1_valid`  out  1  decoded instruction available.
- `s1_ready`  in  1  STAGE1 accepts the instruction.
- `mblock_s1`  out  2  word[31:30]: STAGE1 source select.
- `vr_source`  out  8  word[23:16]: STAGE1 address/constant.
- `s1_op`  out  6  word[29:24].
- `s1_imm`  out  16  word[15:0].
- `s1_pc`  out  PC_WIDTH  PC of the presented instruction.
- `halted`  out  1  core halted.
- `illegal`  out  1  illegal-instruction trap (see Configuration).

## Operation
- States:
  - FETCH: `rom_req`=1, `rom_address`=PC.
  - PRESENT: `s1_valid`=1.
  - HALT.
- Reset: state=FETCH, PC=`RESET_PC`. `s1_valid`, `halted`, `illegal` and all decoded fields are 0.
- FETCH:
  - `rom_req` stays high and `rom_address` stays stable until `rom_ack`.
  - On `rom_ack`, `rom_value` is registered into the decoded fields, `s1_pc`<=PC, and the state goes to PRESENT.
  - Exception: `s1_op`=6'h3F (HALT). The instruction is not presented; the state goes to HALT and `halted`=1.
- PRESENT:
  - Fields hold stable while `s1_valid`=1 and `s1_ready`=0.
  - Transfer occurs on `s1_valid`&`s1_ready`; then PC<=PC+1 and the state goes to FETCH.
  - PC arithmetic wraps modulo 2^PC_WIDTH (e.g. 16'hFFFF -> 16'h0000).
- HALT: no requests and `s1_valid`=0. Only reset or `jump_valid` leaves HALT.
- Jump, in any state: `jump_valid`=1 forces PC<=`jump_target`, state<=FETCH, `s1_valid`<=0, `halted`<=0.
  - A `rom_ack` in the same cycle as the jump is discarded.
  - A transfer in the same cycle as the jump still counts as delivered; PC takes `jump_target`, not PC+1.
- Jump has priority over HALT decode and over PC increment.
- Reset asserted mid-operation clears everything immediately, regardless of outstanding `rom_req`. The memory must tolerate an abandoned request.

## Timing
- `rom_req` is a registered-state decode. It goes high in the first cycle after `reset_n` deasserts.
- `rom_ack` may arrive in the same cycle as `rom_req` (zero wait) or any number of cycles later.
- Fetch latency: `rom_ack` in cycle N gives `s1_valid`=1 in cycle N+1.
- Maximum throughput: one instruction per 2 cycles (FETCH with immediate ack, then PRESENT with `s1_ready`=1).
- After a transfer in cycle N, `rom_req`=1 in cycle N+1 with the new PC.
- A jump in cycle N gives `rom_address`=`jump_target` and `rom_req`=1 in cycle N+1.
- All outputs are registered or state-decoded; there are no combinational paths from inputs to outputs.

## Configuration
- `STAGE0_ILLEGAL_TRAP_EN` defined:
  - A fetched word with `mblock_s1`=2'b01 (a STAGE1 encoding with no source) is not presented.
  - The state goes to HALT with `halted`=1 and `illegal`=1, and `s1_pc` records the offending PC.
  - `illegal` clears on reset or jump.
- `STAGE0_ILLEGAL_TRAP_EN` undefined:
  - `mblock_s1`=2'b01 is presented like any other word.
  - `illegal` is tied to 0.

## Test plan
- Zero-wait ack, `s1_ready`=1, memory[0..2] = 32'h0021_0005, 32'h8022_0000, 32'hC021_0000:
  - `s1_pc` is 0,1,2, one instruction every 2 cycles.
  - `mblock_s1` is 0,2,3; `vr_source` is 33,34,33.
- Backpressure: hold `s1_ready`=0 for 5 cycles while `s1_valid`=1:
  - Fields and `s1_pc` are stable and `rom_req`=0 throughout.
  - Release gives a single transfer, then a fetch of PC+1.
- Delayed ack of 3 cycles:
  - `rom_req` and `rom_address` are stable for 4 cycles.
  - `s1_valid` rises the cycle after the ack.
- Jump to 16'h0040 in the same cycle as `rom_ack`: the acked word is dropped and the next `rom_address` is 16'h0040.
- Jump to 16'h0100 in the same cycle as a transfer: the transfer counts and the next fetch address is 16'h0100.
- HALT and wrap:
  - Word 32'h3F00_0000 gives `halted`=1, `rom_req`=0 and `s1_valid`=0 indefinitely.
  - A later jump resumes fetching.
  - Starting at PC=16'hFFFF, the next fetch address is 16'h0000.
- With `STAGE0_ILLEGAL_TRAP_EN`, word 32'h4000_0000 gives `illegal`=1 and `halted`=1.
- Mid-operation: asserting `reset_n`=0 clears outputs asynchronously.

Source files
------------

// File: rtl/stage0_fetch.sv
// Instruction fetch/decode stage: owns the PC, fetches over req/ack, presents decoded fields to STAGE1.
// Optional illegal-instruction trap on mblock_s1 == 2'b01 is built when STAGE0_ILLEGAL_TRAP_EN is defined.
`timescale 1ns/1ps
module stage0_fetch #(
  parameter int          PC_WIDTH = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [PC_WIDTH-1:0] rom_address,
  output logic                rom_req,
  input  logic [31:0]         rom_value,
  input  logic                rom_ack,
  input  logic                jump_valid,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic                s1_valid,
  input  logic                s1_ready,
  output logic [1:0]          mblock_s1,
  output logic [7:0]          vr_source,
  output logic [5:0]          s1_op,
  output logic [15:0]         s1_imm,
  output logic [PC_WIDTH-1:0] s1_pc,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [1:0]          r_mblock;
  logic [7:0]          r_vr_source;
  logic [5:0]          r_op;
  logic [15:0]         r_imm;
  logic [PC_WIDTH-1:0] r_s1_pc;
  logic                w_take;
  logic                w_is_halt;
  logic                w_is_illegal;

  // An ack coinciding with a jump belongs to the abandoned PC and is dropped.
  assign w_take    = (r_state == ST_FETCH) && rom_ack && !jump_valid;
  assign w_is_halt = (rom_value[29:24] == 6'h3F);

`ifdef STAGE0_ILLEGAL_TRAP_EN
  assign w_is_illegal = (rom_value[31:30] == 2'b01);
`else
  assign w_is_illegal = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      ST_FETCH: begin
        if (rom_ack) begin
          w_state_next = (w_is_halt || w_is_illegal) ? ST_HALT : ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (s1_ready) begin
          w_state_next = ST_FETCH;
          w_pc_next    = r_pc + PC_WIDTH'(1);
        end
      end
      default: begin
        w_state_next = ST_HALT;
      end
    endcase
    // Redirect wins over halt decode and over the sequential increment.
    if (jump_valid) begin
      w_state_next = ST_FETCH;
      w_pc_next    = jump_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
      r_pc    <= PC_WIDTH'(RESET_PC);
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mblock    <= '0;
      r_vr_source <= '0;
      r_op        <= '0;
      r_imm       <= '0;
      r_s1_pc     <= '0;
    end else if (w_take) begin
      r_mblock    <= rom_value[31:30];
      r_op        <= rom_value[29:24];
      r_vr_source <= rom_value[23:16];
      r_imm       <= rom_value[15:0];
      r_s1_pc     <= r_pc;
    end
  end

`ifdef STAGE0_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_illegal <= 1'b0;
    end else if (jump_valid) begin
      r_illegal <= 1'b0;
    end else if (w_take && w_is_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign rom_req     = (r_state == ST_FETCH);
  assign rom_address = r_pc;
  assign s1_valid    = (r_state == ST_PRESENT);
  assign halted      = (r_state == ST_HALT);
  assign mblock_s1   = r_mblock;
  assign vr_source   = r_vr_source;
  assign s1_op       = r_op;
  assign s1_imm      = r_imm;
  assign s1_pc       = r_s1_pc;

endmodule

// File: tb/tb_stage0_fetch.sv
// Self-checking bench for stage0_fetch: vector table plus hand-written corner sequences,
// with a scoreboard of fetched words checked as STAGE1 accepts them.
`timescale 1ns/1ps
module tb_stage0_fetch;

  logic        clk;
  logic        reset_n;
  logic [15:0] rom_address;
  logic        rom_req;
  logic [31:0] rom_value;
  logic        rom_ack;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic        s1_valid;
  logic        s1_ready;
  logic [1:0]  mblock_s1;
  logic [7:0]  vr_source;
  logic [5:0]  s1_op;
  logic [15:0] s1_imm;
  logic [15:0] s1_pc;
  logic        halted;
  logic        illegal;

  stage0_fetch #(.PC_WIDTH(16), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rom_address (rom_address),
    .rom_req     (rom_req),
    .rom_value   (rom_value),
    .rom_ack     (rom_ack),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .s1_valid    (s1_valid),
    .s1_ready    (s1_ready),
    .mblock_s1   (mblock_s1),
    .vr_source   (vr_source),
    .s1_op       (s1_op),
    .s1_imm      (s1_imm),
    .s1_pc       (s1_pc),
    .halted      (halted),
    .illegal     (illegal)
  );

  typedef struct {
    logic [31:0] word;
    logic [1:0]  mb;
    logic [7:0]  vr;
    logic [5:0]  op;
    logic [15:0] imm;
  } vec_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] word;
  } sb_t;

  localparam int NV = 5;

  vec_t        vecs [NV];
  sb_t         sb [$];
  logic [31:0] mem [0:255];
  int          n_checks;
  int          n_fail;
  int          n_xfer;
  int          ack_delay;
  int          wait_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: memory model drives the ack, scoreboard pushes/pops, then advance to #1 after the edge.
  task automatic cycle(input logic rdy, input logic jv, input logic [15:0] jt);
    sb_t e;
    rom_ack = 1'b0;
    if (rom_req) begin
      if (wait_cnt >= ack_delay) begin
        rom_ack   = 1'b1;
        rom_value = mem[rom_address[7:0]];
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (jv) wait_cnt = 0;
    s1_ready    = rdy;
    jump_valid  = jv;
    jump_target = jt;
    if (rom_ack && !jv && rom_value[29:24] != 6'h3F
`ifdef STAGE0_ILLEGAL_TRAP_EN
        && rom_value[31:30] != 2'b01
`endif
       ) begin
      sb.push_back({rom_address, rom_value});
    end
    if (s1_valid && rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: got transfer pc=%h expected no transfer", s1_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc",     32'(s1_pc),     32'(e.pc));
        check("sb_mblock", 32'(mblock_s1), 32'(e.word[31:30]));
        check("sb_op",     32'(s1_op),     32'(e.word[29:24]));
        check("sb_vr",     32'(vr_source), 32'(e.word[23:16]));
        check("sb_imm",    32'(s1_imm),    32'(e.word[15:0]));
        n_xfer++;
        $display("xfer pc=%h mblock=%0d vr=%0d op=%h imm=%h jump=%0b", s1_pc, mblock_s1, vr_source,
                 s1_op, s1_imm, jv);
      end
    end
    @(posedge clk);
    #1;
    rom_ack    = 1'b0;
    jump_valid = 1'b0;
  endtask

  task automatic restart();
    reset_n    = 1'b0;
    rom_ack    = 1'b0;
    jump_valid = 1'b0;
    s1_ready   = 1'b0;
    sb.delete();
    wait_cnt   = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int xfer_before;
    n_checks    = 0;
    n_fail      = 0;
    n_xfer      = 0;
    ack_delay   = 0;
    wait_cnt    = 0;
    reset_n     = 1'b0;
    rom_ack     = 1'b0;
    rom_value   = '0;
    jump_valid  = 1'b0;
    jump_target = '0;
    s1_ready    = 1'b0;

    vecs[0] = '{32'h0021_0005, 2'd0, 8'h21, 6'h00, 16'h0005};
    vecs[1] = '{32'h8022_0000, 2'd2, 8'h22, 6'h00, 16'h0000};
    vecs[2] = '{32'hC021_0000, 2'd3, 8'h21, 6'h00, 16'h0000};
    vecs[3] = '{32'hFE12_3456, 2'd3, 8'h12, 6'h3E, 16'h3456};
    vecs[4] = '{32'h2BCD_7FFF, 2'd0, 8'hCD, 6'h2B, 16'h7FFF};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    for (int i = 0; i < NV; i++) mem[i] = vecs[i].word;
    mem[8'h40] = 32'h1155_AAAA;
    mem[8'h41] = 32'hC3A5_0F0F;
    mem[8'h80] = 32'h3F00_0000;
    mem[8'h90] = 32'h4000_0000;
    mem[8'hFF] = 32'h8077_0001;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s1_valid", 32'(s1_valid), 32'd0);
    check("rst_halted",   32'(halted),   32'd0);
    check("rst_illegal",  32'(illegal),  32'd0);
    check("rst_s1_pc",    32'(s1_pc),    32'd0);
    check("rst_fields",   {mblock_s1, s1_op, vr_source, s1_imm}, 32'd0);
    check("rst_addr",     32'(rom_address), 32'd0);
    reset_n = 1'b1;

    // Zero-wait streaming through the vector table: one instruction per 2 cycles
    for (int c = 0; c < 2 * NV; c++) begin
      if (c % 2 == 0) begin
        check("tbl_req",   32'(rom_req),     32'd1);
        check("tbl_addr",  32'(rom_address), 32'(c / 2));
        check("tbl_valid", 32'(s1_valid),    32'd0);
      end else begin
        check("tbl_valid",  32'(s1_valid),  32'd1);
        check("tbl_req",    32'(rom_req),   32'd0);
        check("tbl_pc",     32'(s1_pc),     32'(c / 2));
        check("tbl_mblock", 32'(mblock_s1), 32'(vecs[c / 2].mb));
        check("tbl_vr",     32'(vr_source), 32'(vecs[c / 2].vr));
        check("tbl_op",     32'(s1_op),     32'(vecs[c / 2].op));
        check("tbl_imm",    32'(s1_imm),    32'(vecs[c / 2].imm));
      end
      cycle(1'b1, 1'b0, 16'h0000);
    end
    check("tbl_next_addr", 32'(rom_address), 32'(NV));

    // Backpressure: 5 cycles of s1_ready=0
    restart();
    cycle(1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(s1_valid),  32'd1);
      check("bp_req",   32'(rom_req),   32'd0);
      check("bp_pc",    32'(s1_pc),     32'd0);
      check("bp_vr",    32'(vr_source), 32'(vecs[0].vr));
      check("bp_imm",   32'(s1_imm),    32'(vecs[0].imm));
      cycle(1'b0, 1'b0, 16'h0000);
    end
    xfer_before = n_xfer;
    cycle(1'b1, 1'b0, 16'h0000);
    check("bp_one_xfer", 32'(n_xfer - xfer_before), 32'd1);
    check("bp_req_after", 32'(rom_req),     32'd1);
    check("bp_addr_after", 32'(rom_address), 32'd1);
    check("bp_valid_after", 32'(s1_valid),  32'd0);

    // Ack delayed 3 cycles
    ack_delay = 3;
    for (int k = 0; k < 4; k++) begin
      check("dly_req",   32'(rom_req),     32'd1);
      check("dly_addr",  32'(rom_address), 32'd1);
      check("dly_valid", 32'(s1_valid),    32'd0);
      cycle(1'b0, 1'b0, 16'h0000);
    end
    check("dly_valid_rise", 32'(s1_valid), 32'd1);
    check("dly_pc",         32'(s1_pc),    32'd1);
    cycle(1'b1, 1'b0, 16'h0000);
    ack_delay = 0;

    // Jump coinciding with an ack: the acked word is dropped
    cycle(1'b0, 1'b1, 16'h0040);
    check("jack_addr",  32'(rom_address), 32'h0040);
    check("jack_req",   32'(rom_req),     32'd1);
    check("jack_valid", 32'(s1_valid),    32'd0);
    cycle(1'b0, 1'b0, 16'h0000);
    check("jack_pc", 32'(s1_pc), 32'h0040);
    cycle(1'b1, 1'b0, 16'h0000);

    // Jump coinciding with a transfer: transfer counts, fetch goes to the target
    check("jx_addr_seq", 32'(rom_address), 32'h0041);
    cycle(1'b0, 1'b0, 16'h0000);
    check("jx_pc", 32'(s1_pc), 32'h0041);
    xfer_before = n_xfer;
    cycle(1'b1, 1'b1, 16'h0100);
    check("jx_counted", 32'(n_xfer - xfer_before), 32'd1);
    check("jx_addr",    32'(rom_address), 32'h0100);
    check("jx_req",     32'(rom_req),     32'd1);
    check("jx_valid",   32'(s1_valid),    32'd0);

    // HALT opcode, resume via jump, PC wrap
    cycle(1'b0, 1'b1, 16'h0080);
    cycle(1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      check("halt_halted", 32'(halted),   32'd1);
      check("halt_req",    32'(rom_req),  32'd0);
      check("halt_valid",  32'(s1_valid), 32'd0);
      cycle(1'b1, 1'b0, 16'h0000);
    end
    cycle(1'b0, 1'b1, 16'hFFFF);
    check("resume_halted", 32'(halted),      32'd0);
    check("resume_req",    32'(rom_req),     32'd1);
    check("resume_addr",   32'(rom_address), 32'h0000_FFFF);
    cycle(1'b0, 1'b0, 16'h0000);
    check("wrap_pc", 32'(s1_pc), 32'h0000_FFFF);
    cycle(1'b1, 1'b0, 16'h0000);
    check("wrap_addr", 32'(rom_address), 32'h0000_0000);

    // mblock_s1 == 2'b01
    cycle(1'b0, 1'b1, 16'h0090);
    cycle(1'b0, 1'b0, 16'h0000);
`ifdef STAGE0_ILLEGAL_TRAP_EN
    check("ill_illegal", 32'(illegal),  32'd1);
    check("ill_halted",  32'(halted),   32'd1);
    check("ill_valid",   32'(s1_valid), 32'd0);
    check("ill_pc",      32'(s1_pc),    32'h0090);
    cycle(1'b0, 1'b1, 16'h0000);
    check("ill_clear",   32'(illegal),  32'd0);
    check("ill_unhalt",  32'(halted),   32'd0);
`else
    check("mb01_illegal", 32'(illegal),   32'd0);
    check("mb01_valid",   32'(s1_valid),  32'd1);
    check("mb01_pc",      32'(s1_pc),     32'h0090);
    check("mb01_mblock",  32'(mblock_s1), 32'd1);
    cycle(1'b1, 1'b0, 16'h0000);
`endif

    // Asynchronous reset while an instruction is being presented
    cycle(1'b0, 1'b1, 16'h0041);
    cycle(1'b0, 1'b0, 16'h0000);
    check("mid_valid_pre", 32'(s1_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_valid",  32'(s1_valid),    32'd0);
    check("mid_pc",     32'(s1_pc),       32'd0);
    check("mid_fields", {mblock_s1, s1_op, vr_source, s1_imm}, 32'd0);
    check("mid_addr",   32'(rom_address), 32'd0);
    check("mid_halted", 32'(halted),      32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, 16'h0000);
    check("post_rst_pc", 32'(s1_pc), 32'd0);
    cycle(1'b1, 1'b0, 16'h0000);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
